// File: rtl/cache_miss_arbiter.sv
// Purpose  : shares one memory read port between N_PORTS miss-handling caches, round-robin,
//            locking a stalled address until memory accepts it; read data is broadcast.
// Latency  : request->memory is combinational; req_data_valid follows an accept by 1 cycle.
// Backpress: mem_addr_ready is forwarded to the winner's req_ready only; losers see 0.
// Ports    : clk/rst (sync, active-high); req_valid/req_addr/req_ready per cache;
//            req_data (broadcast) + req_data_valid (one-hot owner); mem_addr_valid/mem_addr/
//            mem_addr_ready toward memory; mem_data from memory (valid 1 cycle after accept).
module cache_miss_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DWIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            req_valid,
    input  logic [N_PORTS*ADDR_WIDTH-1:0] req_addr,
    output logic [N_PORTS-1:0]            req_ready,
    output logic [DWIDTH-1:0]             req_data,
    output logic [N_PORTS-1:0]            req_data_valid,
    output logic                          mem_addr_valid,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_addr_ready,
    input  logic [DWIDTH-1:0]             mem_data
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {S_ARB, S_HOLD} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_prio;
    logic [PW-1:0]       r_lock_idx;
    logic [N_PORTS-1:0]  r_resp_onehot;

    logic                w_arb_found;
    logic [PW-1:0]       w_arb_idx;
    logic [PW-1:0]       w_scan;
    logic                w_has_win;
    logic [PW-1:0]       w_win_idx;
    logic                w_accept;
    logic [PW-1:0]       w_prio_nxt;
    logic [N_PORTS-1:0]  w_win_onehot;

    // Round-robin scan starting at r_prio. Walking from the farthest offset down to
    // offset 0 means the last hit written is the closest valid port to r_prio.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_scan      = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            w_scan = PW'((int'(r_prio) + k) % N_PORTS);
            if (req_valid[w_scan]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_scan;
            end
        end
    end

    // While holding, only the locked port can win; if it withdrew there is no winner.
    always_comb begin
        if (r_state == S_HOLD) begin
            w_has_win = req_valid[r_lock_idx];
            w_win_idx = r_lock_idx;
        end else begin
            w_has_win = w_arb_found;
            w_win_idx = w_arb_idx;
        end
    end

    assign w_accept = w_has_win && mem_addr_ready;

    always_comb begin
        if (w_win_idx == PW'(N_PORTS - 1)) begin
            w_prio_nxt = '0;
        end else begin
            w_prio_nxt = w_win_idx + 1'b1;
        end
    end

    always_comb begin
        w_win_onehot = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_win_idx == PW'(i)) begin
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. A stalled winner locks; an accept or a withdrawal releases.
    always_comb begin
        w_state_nxt = S_ARB;
        case (r_state)
            S_ARB: begin
                if (w_has_win && !mem_addr_ready) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_has_win && !mem_addr_ready) begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: w_state_nxt = S_ARB;
        endcase
    end

    // FSM: outputs toward memory and requesters
    always_comb begin
        mem_addr_valid = w_has_win;
        mem_addr       = '0;
        req_ready      = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_has_win && (w_win_idx == PW'(i))) begin
                mem_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                req_ready[i] = mem_addr_ready;
            end
        end
    end

    // Arbitration bookkeeping and response qualifier
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio        <= '0;
            r_lock_idx    <= '0;
            r_resp_onehot <= '0;
        end else begin
            r_resp_onehot <= '0;
            if (w_accept) begin
                r_prio        <= w_prio_nxt;
                r_resp_onehot <= w_win_onehot;
            end else if (w_has_win) begin
                r_lock_idx <= w_win_idx;
            end
        end
    end

    // Memory answers one cycle after accept, which is exactly when the qualifier is up.
    assign req_data       = mem_data;
    assign req_data_valid = r_resp_onehot;

endmodule
